// File: rtl/user_id_reader_pkg.sv
// user_id_reader_pkg: FSM encoding and default ID width shared by the user ID reader files
package user_id_reader_pkg;
    localparam int DEF_ID_WIDTH = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, SAMP0 = 2'd1, SAMP1 = 2'd2, SHIFT = 2'd3} state_t;
endpackage

// File: rtl/user_id_reader_shifter.sv
// user_id_reader_shifter: parallel-load bit-serial valid/ready shift-out.
// USER_ID_READER_PARITY_EN appends one odd-parity bit (~^data) after the ID.
module user_id_reader_shifter
    import user_id_reader_pkg::*;
#(
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                adv,
    input  logic [ID_WIDTH-1:0] data,
    output logic                tx_data,
    output logic                tx_last
);
`ifdef USER_ID_READER_PARITY_EN
    localparam int N = ID_WIDTH + 1;
`else
    localparam int N = ID_WIDTH;
`endif
    localparam int CW = $clog2(N + 1);
    logic [ID_WIDTH-1:0] sr;
    logic [CW-1:0]       cnt;
    logic                id_bit;
    assign id_bit  = LSB_FIRST ? sr[0] : sr[ID_WIDTH-1];
    assign tx_last = cnt == CW'(N - 1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= data;
            cnt <= '0;
        end else if (adv) begin
            sr  <= LSB_FIRST ? sr >> 1 : sr << 1;
            cnt <= cnt + 1'b1;
        end
    end
`ifdef USER_ID_READER_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            par <= 1'b0;
        else if (load)
            par <= ~^data;
    end
    assign tx_data = (cnt == CW'(ID_WIDTH)) ? par : id_bit;
`else
    assign tx_data = id_bit;
`endif
endmodule

// File: rtl/user_id_reader.sv
// user_id_reader: double-sampled capture of the mask_rev user ID and bit-serial stream-out.
// Define USER_ID_READER_PARITY_EN to append an odd-parity bit to the stream.
module user_id_reader
    import user_id_reader_pkg::*;
#(
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int MAX_RETRY = 3,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ID_WIDTH-1:0] mask_rev,
    input  logic                capture_req,
    output logic [ID_WIDTH-1:0] id_value,
    output logic                id_valid,
    output logic                id_err,
    input  logic                tx_start,
    output logic                tx_busy,
    output logic                tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_last
);
    state_t              state, state_nx;
    logic                auto_cap;
    logic [3:0]          retry;
    logic [ID_WIDTH-1:0] s0;
    logic                enter_samp, shift_go, match, give_up;
    assign enter_samp = (state == IDLE) && (auto_cap || capture_req);
    assign match      = mask_rev == s0;
    assign give_up    = retry == 4'(MAX_RETRY);
    assign tx_busy    = state != IDLE;
    assign tx_valid   = state == SHIFT;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        shift_go = 1'b0;
        case (state)
            IDLE: begin
                if (enter_samp)
                    state_nx = SAMP0;
                else if (tx_start && (id_valid || id_err)) begin
                    state_nx = SHIFT;
                    shift_go = 1'b1;
                end
            end
            SAMP0:   state_nx = SAMP1;
            SAMP1:   state_nx = (match || give_up) ? IDLE : SAMP0;
            SHIFT:   state_nx = (tx_ready && tx_last) ? IDLE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end
    // A failed double-sample retries only MAX_RETRY times so a floating bus cannot stall housekeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_cap <= 1'b1;
            retry    <= '0;
            s0       <= '0;
            id_value <= '0;
            id_valid <= 1'b0;
            id_err   <= 1'b0;
        end else begin
            if (enter_samp) begin
                auto_cap <= 1'b0;
                retry    <= '0;
                id_valid <= 1'b0;
                id_err   <= 1'b0;
            end
            if (state == SAMP0)
                s0 <= mask_rev;
            if (state == SAMP1) begin
                if (match) begin
                    id_value <= s0;
                    id_valid <= 1'b1;
                end else if (give_up) begin
                    id_value <= mask_rev;
                    id_err   <= 1'b1;
                end else
                    retry <= retry + 1'b1;
            end
        end
    end
    user_id_reader_shifter #(
        .ID_WIDTH (ID_WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_shifter (
        .clk    (clk),
        .resetn (resetn),
        .load   (shift_go),
        .adv    (tx_valid && tx_ready),
        .data   (id_value),
        .tx_data(tx_data),
        .tx_last(tx_last)
    );
endmodule
